// File: rtl/irq_timer_if.sv
// Load/store bus between the pipeline and the irq_timer register block.
// The pipeline drives strobes, address and store data; the block returns load data and a hit flag.
interface irq_timer_if;
   logic        mem_wr;
   logic        mem_read;
   logic [31:0] addr;
   logic [31:0] data_wr;
   logic [31:0] rdata;
   logic        sel;

   modport master (
      output mem_wr,
      output mem_read,
      output addr,
      output data_wr,
      input  rdata,
      input  sel
   );

   modport slave (
      input  mem_wr,
      input  mem_read,
      input  addr,
      input  data_wr,
      output rdata,
      output sel
   );
endinterface

// File: rtl/irq_timer.sv
// Memory-mapped timer plus edge-latched external interrupts, presented as a one-hot
// lowest-index-first interrupt vector to the CSR unit.
module irq_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic           clk,
   input  logic           rst,
   irq_timer_if.slave     bus,
   input  logic [2:0]     ext_irq,
   input  logic           irq_ack,
   output logic [3:0]     interrupt
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   logic [31:0]   mtime_q, mtime_d;
   logic [31:0]   mtimecmp_q, mtimecmp_d;
   logic [3:0]    ie_q, ie_d;
   logic [3:0]    ip_q, ip_d;
   logic [2:0]    ext_prev_q;
   logic [PW-1:0] presc_q, presc_d;

   logic          hit;
   logic [1:0]    off;
   logic          wr_mtime, wr_cmp, wr_ie, wr_ip;
   logic          tick;
   logic [31:0]   mtime_inc;
   logic          timer_evt;
   logic [3:0]    set_vec, clr_vec, pend;
   logic          unused_addr_lsb;

   assign unused_addr_lsb = ^bus.addr[1:0];

   always_comb begin
      hit      = (bus.addr[31:4] == BASE_ADDR[31:4]);
      off      = bus.addr[3:2];
      wr_mtime = hit && bus.mem_wr && (off == 2'd0);
      wr_cmp   = hit && bus.mem_wr && (off == 2'd1);
      wr_ie    = hit && bus.mem_wr && (off == 2'd2);
      wr_ip    = hit && bus.mem_wr && (off == 2'd3);
      bus.sel  = hit;
   end

   // Prescaler and MTIME; a CPU write to MTIME pre-empts the tick and restarts the prescaler.
   always_comb begin
      tick      = (presc_q == PRESC_LAST);
      mtime_inc = mtime_q + 32'd1;
      mtime_d   = mtime_q;
      presc_d   = tick ? '0 : presc_q + PW'(1);
      timer_evt = 1'b0;
      if (wr_mtime) begin
         mtime_d = bus.data_wr;
         presc_d = '0;
      end else if (tick) begin
         mtime_d   = mtime_inc;
         timer_evt = (mtime_inc == mtimecmp_q);
      end
   end

   // Lowest set bit of the enabled pending set: p & -p isolates it.
   always_comb begin
      pend      = ip_q & ie_q;
      interrupt = pend & (~pend + 4'd1);
   end

   always_comb begin
      set_vec    = {ext_irq & ~ext_prev_q, timer_evt};
      clr_vec    = ({4{wr_ip}} & bus.data_wr[3:0]) | ({4{irq_ack}} & interrupt);
      ip_d       = (ip_q & ~clr_vec) | set_vec;
      mtimecmp_d = wr_cmp ? bus.data_wr : mtimecmp_q;
      ie_d       = wr_ie ? bus.data_wr[3:0] : ie_q;
   end

   always_comb begin
      bus.rdata = '0;
      if (hit && bus.mem_read) begin
         unique case (off)
            2'd0:    bus.rdata = mtime_q;
            2'd1:    bus.rdata = mtimecmp_q;
            2'd2:    bus.rdata = {28'd0, ie_q};
            default: bus.rdata = {28'd0, ip_q};
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mtime_q    <= '0;
         mtimecmp_q <= 32'hFFFF_FFFF;
         ie_q       <= '0;
         ip_q       <= '0;
         ext_prev_q <= '0;
         presc_q    <= '0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         ie_q       <= ie_d;
         ip_q       <= ip_d;
         ext_prev_q <= ext_irq;
         presc_q    <= presc_d;
      end
   end

endmodule
